// File: rtl/rvee_axi_arb.sv
// rvee_axi_arb: shares the single rvee AXI4-lite memory port between the
// fetch stage (requester 0) and rvee_mem (requester 1). Reads and writes are
// arbitrated on independent round-robin paths. Each path allows one
// outstanding transaction. All forwarding muxes are driven from the
// registered grant and state.
module rvee_axi_arb #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  // requester read address / data
  input  logic [1:0]                s_arvalid,
  output logic [1:0]                s_arready,
  input  logic [2*AWIDTH-1:0]       s_araddr,
  input  logic [5:0]                s_arprot,
  output logic [1:0]                s_rvalid,
  input  logic [1:0]                s_rready,
  output logic [DWIDTH-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  // requester write address / data / response
  input  logic [1:0]                s_awvalid,
  output logic [1:0]                s_awready,
  input  logic [2*AWIDTH-1:0]       s_awaddr,
  input  logic [5:0]                s_awprot,
  input  logic [1:0]                s_wvalid,
  output logic [1:0]                s_wready,
  input  logic [2*DWIDTH-1:0]       s_wdata,
  input  logic [2*(DWIDTH/8)-1:0]   s_wstrb,
  output logic [1:0]                s_bvalid,
  input  logic [1:0]                s_bready,
  output logic [1:0]                s_bresp,
  // master read
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [AWIDTH-1:0]         m_araddr,
  output logic [2:0]                m_arprot,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DWIDTH-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  // master write
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [AWIDTH-1:0]         m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [DWIDTH-1:0]         m_wdata,
  output logic [DWIDTH/8-1:0]       m_wstrb,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp
);

  localparam int SWIDTH = DWIDTH / 8;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;

  rd_state_t r_rd_state;
  logic      r_rd_gnt;
  logic      r_last_r;

  wr_state_t r_wr_state;
  logic      r_wr_gnt;
  logic      r_last_w;
  logic      r_aw_done;
  logic      r_w_done;

  logic [1:0] w_wr_req;
  logic       w_rd_pick;
  logic       w_wr_pick;
  logic       w_rd_addr_ph;
  logic       w_rd_data_ph;
  logic       w_wr_xfer_ph;
  logic       w_wr_resp_ph;
  logic       w_aw_open;
  logic       w_w_open;
  logic       w_ar_fire;
  logic       w_r_fire;
  logic       w_aw_fire;
  logic       w_w_fire;
  logic       w_b_fire;
  logic       w_aw_all;
  logic       w_w_all;

  // Round-robin pick: on contention the requester that did not win last time
  // goes first, otherwise the lone requester wins.
  assign w_rd_pick = (&s_arvalid) ? ~r_last_r : s_arvalid[1];
  assign w_wr_req  = s_awvalid | s_wvalid;
  assign w_wr_pick = (&w_wr_req) ? ~r_last_w : w_wr_req[1];

  assign w_rd_addr_ph = (r_rd_state == R_ADDR);
  assign w_rd_data_ph = (r_rd_state == R_DATA);
  assign w_wr_xfer_ph = (r_wr_state == W_XFER);
  assign w_wr_resp_ph = (r_wr_state == W_RESP);

  // An AW or W channel stays open only until its own master handshake.
  assign w_aw_open = w_wr_xfer_ph & ~r_aw_done;
  assign w_w_open  = w_wr_xfer_ph & ~r_w_done;

  // Master-side forwarding from the granted requester
  assign m_arvalid = w_rd_addr_ph & s_arvalid[r_rd_gnt];
  assign m_araddr  = r_rd_gnt ? s_araddr[AWIDTH +: AWIDTH] : s_araddr[0 +: AWIDTH];
  assign m_arprot  = r_rd_gnt ? s_arprot[5:3] : s_arprot[2:0];
  assign m_rready  = w_rd_data_ph & s_rready[r_rd_gnt];

  assign m_awvalid = w_aw_open & s_awvalid[r_wr_gnt];
  assign m_awaddr  = r_wr_gnt ? s_awaddr[AWIDTH +: AWIDTH] : s_awaddr[0 +: AWIDTH];
  assign m_awprot  = r_wr_gnt ? s_awprot[5:3] : s_awprot[2:0];
  assign m_wvalid  = w_w_open & s_wvalid[r_wr_gnt];
  assign m_wdata   = r_wr_gnt ? s_wdata[DWIDTH +: DWIDTH] : s_wdata[0 +: DWIDTH];
  assign m_wstrb   = r_wr_gnt ? s_wstrb[SWIDTH +: SWIDTH] : s_wstrb[0 +: SWIDTH];
  assign m_bready  = w_wr_resp_ph & s_bready[r_wr_gnt];

  // Response payloads are shared; only the valid is steered.
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_bresp = m_bresp;

  assign w_ar_fire = m_arvalid & m_arready;
  assign w_r_fire  = m_rvalid  & m_rready;
  assign w_aw_fire = m_awvalid & m_awready;
  assign w_w_fire  = m_wvalid  & m_wready;
  assign w_b_fire  = m_bvalid  & m_bready;
  assign w_aw_all  = r_aw_done | w_aw_fire;
  assign w_w_all   = r_w_done  | w_w_fire;

  // Per-requester ready/valid steering. The non-granted side sees all zeros.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic w_rd_sel;
      logic w_wr_sel;
      assign w_rd_sel      = (gi == 1) ? r_rd_gnt : ~r_rd_gnt;
      assign w_wr_sel      = (gi == 1) ? r_wr_gnt : ~r_wr_gnt;
      assign s_arready[gi] = w_rd_sel & w_rd_addr_ph & m_arready;
      assign s_rvalid[gi]  = w_rd_sel & w_rd_data_ph & m_rvalid;
      assign s_awready[gi] = w_wr_sel & w_aw_open & m_awready;
      assign s_wready[gi]  = w_wr_sel & w_w_open & m_wready;
      assign s_bvalid[gi]  = w_wr_sel & w_wr_resp_ph & m_bvalid;
    end
  endgenerate

  // Read path FSM: register the grant, forward one AR, then one R beat.
  // r_last_r resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_gnt   <= 1'b0;
      r_last_r   <= 1'b1;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (|s_arvalid) begin
            r_rd_gnt   <= w_rd_pick;
            r_rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (w_ar_fire) r_rd_state <= R_DATA;
        end
        R_DATA: begin
          if (w_r_fire) begin
            r_last_r   <= r_rd_gnt;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Write path FSM: AW and W complete independently (either order or the
  // same cycle); then the single B beat is returned to the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_gnt   <= 1'b0;
      r_last_w   <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (|w_wr_req) begin
            r_wr_gnt   <= w_wr_pick;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= W_XFER;
          end
        end
        W_XFER: begin
          if (w_aw_all && w_w_all) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= W_RESP;
          end else begin
            r_aw_done <= w_aw_all;
            r_w_done  <= w_w_all;
          end
        end
        W_RESP: begin
          if (w_b_fire) begin
            r_last_w   <= r_wr_gnt;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvee_axi_arb.sv
// Randomised bench for rvee_axi_arb: two requester models, a randomly
// stalling AXI4-lite slave, and a transaction-level model of the arbiter's
// grant order and routing rules.
module tb_rvee_axi_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
  logic [2*AW-1:0] s_araddr, s_awaddr;
  logic [5:0]      s_arprot, s_awprot;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp, s_bresp;
  logic [1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [2*DW-1:0] s_wdata;
  logic [2*SW-1:0] s_wstrb;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]   m_araddr, m_awaddr;
  logic [2:0]      m_arprot, m_awprot;
  logic [DW-1:0]   m_rdata, m_wdata;
  logic [1:0]      m_rresp, m_bresp;
  logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [SW-1:0]   m_wstrb;

  rvee_axi_arb #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  // Round-robin rule: alternate on contention, else the lone requester.
  function automatic logic pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  // Slave read data is a fixed function of the address it was sent.
  function automatic logic [31:0] rfun(input logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  // requester state
  logic [1:0]  rd_en, wr_en, rr_block;
  int          rq_ph[2], rq_gap[2], wq_ph[2], wq_gap[2], wq_awd[2], wq_wd[2];
  logic        wq_aws[2], wq_ws[2];
  logic [31:0] rq_addr[2], wq_addr[2], wq_data[2];
  logic [2:0]  rq_prot[2], wq_prot[2];
  logic [3:0]  wq_strb[2];
  int          n_rd_done[2], n_wr_done[2];
  // slave state
  int          sr_ph, sr_dly, sw_ph, sw_dly;
  logic [31:0] sr_data;
  logic [1:0]  sr_resp, sw_resp;
  logic        sw_gaw, sw_gw;
  // arbiter model
  int          mr_ph, mw_ph;
  logic        mr_own, mr_last, mw_own, mw_last, mw_awd, mw_wd;
  // handshakes seen before the coming edge
  logic        mar_f, mr_f, maw_f, mw_f, mb_f;
  logic [1:0]  sar_f, sr_f, saw_f, sw_f, sb_f, snap_srv;
  logic [31:0] snap_araddr;

  task automatic reset_bench();
    s_arvalid = '0; s_araddr = '0; s_arprot = '0; s_rready = '0;
    s_awvalid = '0; s_awaddr = '0; s_awprot = '0; s_wvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_bready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
    for (int i = 0; i < 2; i++) begin
      rq_ph[i] = 0; rq_gap[i] = 0; wq_ph[i] = 0; wq_gap[i] = 0;
      wq_aws[i] = 1'b0; wq_ws[i] = 1'b0;
    end
    sr_ph = 0; sr_dly = 0; sw_ph = 0; sw_dly = 0; sw_gaw = 1'b0; sw_gw = 1'b0;
    mr_ph = 0; mr_last = 1'b1; mr_own = 1'b0;
    mw_ph = 0; mw_last = 1'b1; mw_own = 1'b0; mw_awd = 1'b0; mw_wd = 1'b0;
    snap_srv = '0;
  endtask

  function automatic logic busy();
    return (rq_ph[0] != 0) || (rq_ph[1] != 0) || (wq_ph[0] != 0) || (wq_ph[1] != 0) ||
           (mr_ph != 0) || (mw_ph != 0);
  endfunction

  // One clock: check at the negedge against the model, then drive new stimulus after the posedge.
  task automatic step();
    int o;
    logic a, w;
    @(negedge clk);
    mar_f = m_arvalid & m_arready; mr_f = m_rvalid & m_rready;
    maw_f = m_awvalid & m_awready; mw_f = m_wvalid & m_wready; mb_f = m_bvalid & m_bready;
    sar_f = s_arvalid & s_arready; sr_f = s_rvalid & s_rready;
    saw_f = s_awvalid & s_awready; sw_f = s_wvalid & s_wready; sb_f = s_bvalid & s_bready;
    snap_srv = s_rvalid; snap_araddr = m_araddr;

    o = mr_own ? 1 : 0;
    case (mr_ph)
      0: chk("rd_idle_quiet", {m_arvalid, m_rready, s_arready, s_rvalid}, 0);
      1: begin
        chk("ar_valid", m_arvalid, s_arvalid[o]);
        chk("ar_ready_route", s_arready, oh(mr_own) & {2{m_arready}});
        chk("rd_addr_quiet", {m_rready, s_rvalid}, 0);
        if (mar_f) begin
          chk("ar_addr", m_araddr, rq_addr[o]);
          chk("ar_prot", m_arprot, rq_prot[o]);
        end
      end
      default: begin
        chk("r_valid_route", s_rvalid, oh(mr_own) & {2{m_rvalid}});
        chk("r_ready", m_rready, s_rready[o]);
        chk("rd_data_quiet", {m_arvalid, s_arready}, 0);
      end
    endcase
    for (int i = 0; i < 2; i++) if (sr_f[i]) begin
      chk("r_data", s_rdata, rfun(rq_addr[i]));
      chk("r_resp", s_rresp, sr_resp);
    end

    o = mw_own ? 1 : 0;
    case (mw_ph)
      0: chk("wr_idle_quiet", {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}, 0);
      1: begin
        chk("aw_valid", m_awvalid, s_awvalid[o] & ~mw_awd);
        chk("w_valid", m_wvalid, s_wvalid[o] & ~mw_wd);
        chk("aw_ready_route", s_awready, oh(mw_own) & {2{m_awready & ~mw_awd}});
        chk("w_ready_route", s_wready, oh(mw_own) & {2{m_wready & ~mw_wd}});
        chk("wr_xfer_quiet", {m_bready, s_bvalid}, 0);
        if (maw_f) begin
          chk("aw_addr", m_awaddr, wq_addr[o]);
          chk("aw_prot", m_awprot, wq_prot[o]);
        end
        if (mw_f) begin
          chk("w_data", m_wdata, wq_data[o]);
          chk("w_strb", m_wstrb, wq_strb[o]);
        end
      end
      default: begin
        chk("b_valid_route", s_bvalid, oh(mw_own) & {2{m_bvalid}});
        chk("b_ready", m_bready, s_bready[o]);
        chk("wr_resp_quiet", {m_awvalid, m_wvalid, s_awready, s_wready}, 0);
      end
    endcase
    for (int i = 0; i < 2; i++) if (sb_f[i]) chk("b_resp", s_bresp, sw_resp);

    // advance the arbiter model across the coming edge
    case (mr_ph)
      0: if (|s_arvalid) begin mr_own = pick(s_arvalid, mr_last); mr_ph = 1; end
      1: if (mar_f) mr_ph = 2;
      default: if (mr_f) begin mr_last = mr_own; mr_ph = 0; end
    endcase
    case (mw_ph)
      0: if (|(s_awvalid | s_wvalid)) begin
        mw_own = pick(s_awvalid | s_wvalid, mw_last); mw_ph = 1; mw_awd = 1'b0; mw_wd = 1'b0;
      end
      1: begin
        a = mw_awd | maw_f; w = mw_wd | mw_f;
        if (a && w) begin mw_ph = 2; mw_awd = 1'b0; mw_wd = 1'b0; end
        else begin mw_awd = a; mw_wd = w; end
      end
      default: if (mb_f) begin mw_last = mw_own; mw_ph = 0; end
    endcase

    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      // read requester: hold AR until accepted, then wait for its R beat
      case (rq_ph[i])
        0: if (rq_gap[i] > 0) rq_gap[i]--;
           else if (rd_en[i]) begin
             rq_addr[i] = {i[0], 29'($urandom), 2'b00};
             rq_prot[i] = 3'($urandom);
             s_araddr[i*AW +: AW] = rq_addr[i];
             s_arprot[i*3 +: 3] = rq_prot[i];
             s_arvalid[i] = 1'b1;
             rq_ph[i] = 1;
           end
        1: if (sar_f[i]) begin s_arvalid[i] = 1'b0; rq_ph[i] = 2; end
        default: if (sr_f[i]) begin n_rd_done[i]++; rq_ph[i] = 0; rq_gap[i] = $urandom_range(0, 3); end
      endcase
      s_rready[i] = (rq_ph[i] == 2) && !rr_block[i] && ($urandom_range(0, 2) != 0);
      // write requester: AW and W start after independent delays
      case (wq_ph[i])
        0: if (wq_gap[i] > 0) wq_gap[i]--;
           else if (wr_en[i]) begin
             wq_addr[i] = {i[0], 29'($urandom), 2'b00};
             wq_data[i] = {i[0], 31'($urandom)};
             wq_strb[i] = 4'($urandom);
             wq_prot[i] = 3'($urandom);
             s_awaddr[i*AW +: AW] = wq_addr[i];
             s_awprot[i*3 +: 3] = wq_prot[i];
             s_wdata[i*DW +: DW] = wq_data[i];
             s_wstrb[i*SW +: SW] = wq_strb[i];
             wq_awd[i] = $urandom_range(0, 3); wq_wd[i] = $urandom_range(0, 3);
             wq_aws[i] = 1'b0; wq_ws[i] = 1'b0;
             wq_ph[i] = 1;
           end
        1: begin
          if (saw_f[i]) begin s_awvalid[i] = 1'b0; wq_aws[i] = 1'b1; end
          if (sw_f[i]) begin s_wvalid[i] = 1'b0; wq_ws[i] = 1'b1; end
          if (wq_aws[i] && wq_ws[i]) wq_ph[i] = 2;
        end
        default: if (sb_f[i]) begin n_wr_done[i]++; wq_ph[i] = 0; wq_gap[i] = $urandom_range(0, 3); end
      endcase
      if (wq_ph[i] == 1) begin
        if (!wq_aws[i] && !s_awvalid[i]) begin
          if (wq_awd[i] == 0) s_awvalid[i] = 1'b1; else wq_awd[i]--;
        end
        if (!wq_ws[i] && !s_wvalid[i]) begin
          if (wq_wd[i] == 0) s_wvalid[i] = 1'b1; else wq_wd[i]--;
        end
      end
      s_bready[i] = (wq_ph[i] == 2) && ($urandom_range(0, 2) != 0);
    end
    // read slave
    case (sr_ph)
      0: if (mar_f) begin
           sr_data = rfun(snap_araddr); sr_resp = 2'($urandom);
           sr_dly = $urandom_range(0, 3); sr_ph = 1;
         end
      1: if (sr_dly == 0) begin
           m_rvalid = 1'b1; m_rdata = sr_data; m_rresp = sr_resp; sr_ph = 2;
         end else sr_dly--;
      default: if (mr_f) begin m_rvalid = 1'b0; sr_ph = 0; end
    endcase
    m_arready = (sr_ph == 0) && ($urandom_range(0, 1) == 1);
    // write slave
    case (sw_ph)
      0: begin
        if (maw_f) sw_gaw = 1'b1;
        if (mw_f) sw_gw = 1'b1;
        if (sw_gaw && sw_gw) begin
          sw_resp = 2'($urandom); sw_dly = $urandom_range(0, 3);
          sw_gaw = 1'b0; sw_gw = 1'b0; sw_ph = 1;
        end
      end
      1: if (sw_dly == 0) begin m_bvalid = 1'b1; m_bresp = sw_resp; sw_ph = 2; end
         else sw_dly--;
      default: if (mb_f) begin m_bvalid = 1'b0; sw_ph = 0; end
    endcase
    m_awready = (sw_ph == 0) && !sw_gaw && ($urandom_range(0, 1) == 1);
    m_wready  = (sw_ph == 0) && !sw_gw && ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    int target;
    rd_en = '0; wr_en = '0; rr_block = '0;
    n_rd_done[0] = 0; n_rd_done[1] = 0; n_wr_done[0] = 0; n_wr_done[1] = 0;
    reset_bench();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outs", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                       s_arready, s_rvalid, s_awready, s_wready, s_bvalid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // concurrent randomised traffic on both paths from both requesters
    rd_en = 2'b11; wr_en = 2'b11;
    repeat (3000) step();
    rd_en = '0; wr_en = '0;
    for (int k = 0; k < 300 && busy(); k++) step();
    chk("drain_idle", busy(), 0);
    chk("rd0_progress", n_rd_done[0] > 20, 1);
    chk("rd1_progress", n_rd_done[1] > 20, 1);
    chk("wr0_progress", n_wr_done[0] > 20, 1);
    chk("wr1_progress", n_wr_done[1] > 20, 1);

    // reset while requester 0 waits in the data phase with R valid held
    rd_en = 2'b01; rr_block = 2'b01;
    for (int k = 0; k < 60 && !snap_srv[0]; k++) step();
    chk("rd0_reaches_data", snap_srv[0], 1);
    rd_en = '0;
    #2 rst = 1'b1;
    #1 chk("async_rst_quiet", {s_rvalid, s_arready, m_arvalid, m_rready, s_bvalid, m_awvalid}, 0);
    @(posedge clk); #1;
    reset_bench();
    rr_block = '0;
    rst = 1'b0;

    // requester 1 reads are granted normally after release
    rd_en = 2'b10;
    target = n_rd_done[1] + 2;
    for (int k = 0; k < 100 && n_rd_done[1] < target; k++) step();
    chk("rd1_after_rst", n_rd_done[1] >= target, 1);
    rd_en = '0;
    for (int k = 0; k < 50 && busy(); k++) step();
    chk("final_idle", busy(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
